// File: rtl/tilt_warp_pkg.sv
// Shared constants, k lookup table and tilt clamp for the tilt warp pipeline.
package tilt_warp_pkg;

    localparam int unsigned K_ENTRIES = 113;
    localparam int unsigned K_MAX_IDX = K_ENTRIES - 1;
    localparam logic [7:0]  K_SAT     = 8'd255;
    localparam int unsigned K_FRAC    = 7;

    typedef logic [K_ENTRIES-1:0][7:0] k_table_t;

    // Table is piecewise-linear between calibration points (idx, k):
    // (0,128) (23,142) (32,149) (64,178) (66,181) (112,254); integer
    // truncation keeps it monotonic non-decreasing.
    function automatic k_table_t build_k_table();
        k_table_t    tbl;
        int unsigned a, b, ka, kb;
        tbl = '0;
        for (int unsigned i = 0; i < K_ENTRIES; i++) begin
            if (i <= 23) begin
                a = 0;  b = 23;  ka = 128; kb = 142;
            end else if (i <= 32) begin
                a = 23; b = 32;  ka = 142; kb = 149;
            end else if (i <= 64) begin
                a = 32; b = 64;  ka = 149; kb = 178;
            end else if (i <= 66) begin
                a = 64; b = 66;  ka = 178; kb = 181;
            end else begin
                a = 66; b = 112; ka = 181; kb = 254;
            end
            tbl[i] = 8'(ka + ((kb - ka) * (i - a)) / (b - a));
        end
        return tbl;
    endfunction

    localparam k_table_t K_TABLE = build_k_table();

    // Halve the raw sine sample (arithmetic) and clamp to +/-limit.
    function automatic int clamp_tilt(input int sample, input int limit);
        int half;
        half = sample >>> 1;
        if (half > limit)
            return limit;
        if (half < -limit)
            return -limit;
        return half;
    endfunction

endpackage

// File: rtl/tilt_k_rom.sv
// Combinational index -> k (Q1.7) lookup, saturating to K_SAT past the table.
module tilt_k_rom #(
    parameter int unsigned IDX_W = 14
) (
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       k
);
    import tilt_warp_pkg::*;

    // Table read with saturation for indices beyond the last entry.
    always_comb begin
        k = K_SAT;
        if (32'(idx) <= K_MAX_IDX)
            k = K_TABLE[idx[6:0]];
    end

endmodule

// File: rtl/tilt_warp_pipe.sv
// Three-stage pipelined perspective tilt warp with valid/ready backpressure.
// S1: tilt product, S2: cross-coupled k lookup, S3: scale about the pivot.
module tilt_warp_pipe #(
    parameter int unsigned COORD_W    = 11,
    parameter int unsigned SCREEN_W   = 480,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned CENTER_X   = 240,
    parameter int unsigned CENTER_Y   = 240,
    parameter int unsigned TILT_LIMIT = 60,
    parameter int unsigned IDX_SHIFT  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [COORD_W-1:0] sin_x,
    input  logic signed [COORD_W-1:0] sin_y,
    input  logic                      tilt_apply,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic        [COORD_W-1:0] x_in,
    input  logic        [COORD_W-1:0] y_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [COORD_W-1:0] x_out,
    output logic        [COORD_W-1:0] y_out,
    output logic                      x_oob,
    output logic                      y_oob
);
    import tilt_warp_pkg::*;

    localparam int unsigned PW = 2 * COORD_W;
    localparam int unsigned MW = 2 * COORD_W + 8;
    localparam int unsigned IW = PW - IDX_SHIFT;

    // Positive tilt weights distance from 0, negative tilt distance from the far edge.
    function automatic logic [PW-1:0] axis_product(
        input logic        [COORD_W-1:0] c,
        input logic signed [COORD_W-1:0] d,
        input int unsigned               screen
    );
        logic [COORD_W-1:0] mag;
        logic [COORD_W-1:0] base;
        if (d[COORD_W-1]) begin
            mag  = COORD_W'(-d);
            base = COORD_W'(screen - 1) - c;
        end else begin
            mag  = d;
            base = c;
        end
        return PW'(base) * PW'(mag);
    endfunction

    // Returns {oob, coord}; coord is forced to 0 when off screen.
    function automatic logic [COORD_W:0] axis_scale(
        input logic [COORD_W-1:0] c,
        input logic [7:0]         k,
        input int unsigned        center,
        input int unsigned        screen
    );
        logic signed [MW-1:0] diff;
        logic signed [MW-1:0] m;
        logic signed [MW-1:0] r;
        logic                 oob;
        logic [COORD_W-1:0]   coord;
        diff  = $signed(MW'(c)) - $signed(MW'(center));
        m     = diff * $signed(MW'(k));
        r     = $signed(MW'(center)) + (m >>> K_FRAC);
        oob   = r[MW-1] || (r >= $signed(MW'(screen)));
        coord = oob ? '0 : r[COORD_W-1:0];
        return {oob, coord};
    endfunction

    logic signed [COORD_W-1:0] dx, dy;
    logic signed [COORD_W-1:0] dx_new, dy_new;
    logic signed [COORD_W-1:0] dx_eff, dy_eff;

    logic               s1_valid, s2_valid;
    logic [COORD_W-1:0] s1_x, s1_y, s2_x, s2_y;
    logic [PW-1:0]      s1_tx, s1_ty;
    logic [7:0]         s2_kx, s2_ky;
    logic [IW-1:0]      idx_x, idx_y;
    logic [7:0]         kx, ky;
    logic [COORD_W:0]   x_res, y_res;

    assign in_ready = !out_valid || out_ready;

    // Clamped candidate tilt; a pixel accepted alongside tilt_apply sees it immediately.
    always_comb begin
        dx_new = COORD_W'(clamp_tilt(int'(sin_x), int'(TILT_LIMIT)));
        dy_new = COORD_W'(clamp_tilt(int'(sin_y), int'(TILT_LIMIT)));
        dx_eff = tilt_apply ? dx_new : dx;
        dy_eff = tilt_apply ? dy_new : dy;
    end

    // Active tilt registers, updated only on the frame-boundary strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx <= '0;
            dy <= '0;
        end else if (tilt_apply) begin
            dx <= dx_new;
            dy <= dy_new;
        end
    end

    // k indices: x scale uses the y product and vice versa.
    always_comb begin
        idx_x = IW'(s1_ty >> IDX_SHIFT);
        idx_y = IW'(s1_tx >> IDX_SHIFT);
    end

    tilt_k_rom #(.IDX_W(IW)) u_kx (.idx(idx_x), .k(kx));
    tilt_k_rom #(.IDX_W(IW)) u_ky (.idx(idx_y), .k(ky));

    // Final scale about the pivot for both axes.
    always_comb begin
        x_res = axis_scale(s2_x, s2_kx, CENTER_X, SCREEN_W);
        y_res = axis_scale(s2_y, s2_ky, CENTER_Y, SCREEN_H);
    end

    // Whole pipeline advances together whenever the output slot is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_tx     <= '0;
            s1_ty     <= '0;
            s2_valid  <= 1'b0;
            s2_x      <= '0;
            s2_y      <= '0;
            s2_kx     <= '0;
            s2_ky     <= '0;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            x_oob     <= 1'b0;
            y_oob     <= 1'b0;
        end else if (in_ready) begin
            s1_valid  <= in_valid;
            s1_x      <= x_in;
            s1_y      <= y_in;
            s1_tx     <= axis_product(x_in, dx_eff, SCREEN_W);
            s1_ty     <= axis_product(y_in, dy_eff, SCREEN_H);
            s2_valid  <= s1_valid;
            s2_x      <= s1_x;
            s2_y      <= s1_y;
            s2_kx     <= kx;
            s2_ky     <= ky;
            out_valid <= s2_valid;
            x_oob     <= x_res[COORD_W];
            x_out     <= x_res[COORD_W-1:0];
            y_oob     <= y_res[COORD_W];
            y_out     <= y_res[COORD_W-1:0];
        end
    end

endmodule

// File: tb/tb_tilt_warp_pipe.sv
// Directed and handshake-stress bench for tilt_warp_pipe.
module tb_tilt_warp_pipe;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [10:0] sin_x, sin_y;
    logic               tilt_apply;
    logic               in_valid, in_ready;
    logic        [10:0] x_in, y_in;
    logic               out_valid, out_ready;
    logic        [10:0] x_out, y_out;
    logic               x_oob, y_oob;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tilt_warp_pipe #(
        .COORD_W(11), .SCREEN_W(480), .SCREEN_H(480),
        .CENTER_X(240), .CENTER_Y(240), .TILT_LIMIT(60), .IDX_SHIFT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sin_x(sin_x), .sin_y(sin_y),
        .tilt_apply(tilt_apply), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .x_oob(x_oob), .y_oob(y_oob)
    );

    // dx = 60, dy = 0: (x,y) in, expected (x,y,oobs) out
    logic [10:0] VX  [7] = '{11'd100, 11'd137, 11'd274, 11'd282, 11'd479, 11'd2047, 11'd100};
    logic [10:0] VY  [7] = '{11'd400, 11'd400, 11'd400, 11'd400, 11'd400, 11'd400,  11'd80};
    logic [10:0] EX  [7] = '{11'd100, 11'd137, 11'd274, 11'd282, 11'd479, 11'd0,    11'd100};
    logic [10:0] EY  [7] = '{11'd417, 11'd426, 11'd462, 11'd466, 11'd0,   11'd0,    11'd62};
    logic        EXO [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        EYO [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic apply_tilt(input int sx, input int sy);
        @(negedge clk);
        sin_x = 11'(sx);
        sin_y = 11'(sy);
        tilt_apply = 1'b1;
        @(negedge clk);
        tilt_apply = 1'b0;
    endtask

    task automatic send_one(input logic [10:0] x, input logic [10:0] y,
                            output logic [10:0] ox, output logic [10:0] oy,
                            output logic oxo, output logic oyo, output bit got);
        @(negedge clk);
        x_in = x; y_in = y; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        got = 1'b0;
        ox = '0; oy = '0; oxo = 1'b0; oyo = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got = 1'b1;
                ox = x_out; oy = y_out; oxo = x_oob; oyo = y_oob;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sin_x = '0; sin_y = '0; tilt_apply = 1'b0;
        in_valid = 1'b0; x_in = '0; y_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || x_out !== 11'd0 || y_out !== 11'd0 ||
            x_oob !== 1'b0 || y_oob !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b x=%0d y=%0d oob=%b%b exp all 0",
                     out_valid, x_out, y_out, x_oob, y_oob);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_zero_stream();
        apply_tilt(0, 0);
        for (int c = 0; c < 482; c++) begin
            @(negedge clk);
            in_valid = (c < 480);
            x_in = 11'(c);
            y_in = 11'(c);
            @(posedge clk);
            #1;
            total++;
            if (c < 2) begin
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL latency_early c=%0d got valid=%b exp 0", c, out_valid);
                end
            end else if (out_valid !== 1'b1 || x_out !== 11'(c - 2) || y_out !== 11'(c - 2) ||
                         x_oob !== 1'b0 || y_oob !== 1'b0) begin
                bad++;
                $display("FAIL zero_stream c=%0d got v=%b x=%0d y=%0d oob=%b%b exp v=1 x=y=%0d oob=00",
                         c, out_valid, x_out, y_out, x_oob, y_oob, c - 2);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_stream_drain got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_tilt_x();
        logic [10:0] ox, oy;
        logic        oxo, oyo;
        bit          got;
        apply_tilt(120, 0);
        for (int i = 0; i < 7; i++) begin
            send_one(VX[i], VY[i], ox, oy, oxo, oyo, got);
            total++;
            if (!got || ox !== EX[i] || oy !== EY[i] || oxo !== EXO[i] || oyo !== EYO[i]) begin
                bad++;
                $display("FAIL tilt_x[%0d] got v=%b x=%0d y=%0d oob=%b%b exp x=%0d y=%0d oob=%b%b",
                         i, got, ox, oy, oxo, oyo, EX[i], EY[i], EXO[i], EYO[i]);
            end
        end
    endtask

    task automatic test_tilt_y();
        logic [10:0] ox, oy;
        logic        oxo, oyo;
        bit          got;
        apply_tilt(0, 120);
        send_one(11'd0, 11'd479, ox, oy, oxo, oyo, got);
        total++;
        if (!got || ox !== 11'd0 || oxo !== 1'b1 || oy !== 11'd479 || oyo !== 1'b0) begin
            bad++;
            $display("FAIL tilt_y_oob got v=%b x=%0d y=%0d oob=%b%b exp x=0 y=479 oob=10",
                     got, ox, oy, oxo, oyo);
        end
        send_one(11'd240, 11'd479, ox, oy, oxo, oyo, got);
        total++;
        if (!got || ox !== 11'd240 || oxo !== 1'b0 || oy !== 11'd479 || oyo !== 1'b0) begin
            bad++;
            $display("FAIL tilt_y_pivot got v=%b x=%0d y=%0d oob=%b%b exp x=240 y=479 oob=00",
                     got, ox, oy, oxo, oyo);
        end
    endtask

    task automatic test_clamp();
        logic [10:0] ox, oy;
        logic        oxo, oyo;
        bit          got;
        apply_tilt(1000, 0);
        send_one(11'd100, 11'd400, ox, oy, oxo, oyo, got);
        total++;
        if (!got || ox !== 11'd100 || oy !== 11'd417 || oyo !== 1'b0) begin
            bad++;
            $display("FAIL clamp_pos got v=%b x=%0d y=%0d yoob=%b exp x=100 y=417 yoob=0",
                     got, ox, oy, oyo);
        end
        apply_tilt(-1024, 0);
        send_one(11'd479, 11'd400, ox, oy, oxo, oyo, got);
        total++;
        if (!got || ox !== 11'd479 || oy !== 11'd400 || oxo !== 1'b0 || oyo !== 1'b0) begin
            bad++;
            $display("FAIL neg_edge_identity got v=%b x=%0d y=%0d oob=%b%b exp x=479 y=400 oob=00",
                     got, ox, oy, oxo, oyo);
        end
        send_one(11'd379, 11'd400, ox, oy, oxo, oyo, got);
        total++;
        if (!got || ox !== 11'd379 || oy !== 11'd417 || oyo !== 1'b0) begin
            bad++;
            $display("FAIL clamp_neg got v=%b x=%0d y=%0d yoob=%b exp x=379 y=417 yoob=0",
                     got, ox, oy, oyo);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [21:0] q[$];
        int          sent = 0, rcvd = 0, cycles = 0;
        logic        fire_in, fire_out;
        logic [21:0] exp_v;
        apply_tilt(0, 0);
        while (rcvd < 1000 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 1000) && ($urandom_range(0, 4) != 0);
            x_in = 11'((sent * 37) % 480);
            y_in = 11'((sent * 101 + 3) % 480);
            #1;
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("FAIL rand_ready cycle=%0d got=%b exp=%b", cycles, in_ready,
                         !out_valid || out_ready);
            end
            if (out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra cycle=%0d got x=%0d y=%0d exp no output",
                             cycles, x_out, y_out);
                end else begin
                    exp_v = q[0];
                    if (x_out !== exp_v[21:11] || y_out !== exp_v[10:0] ||
                        x_oob !== 1'b0 || y_oob !== 1'b0) begin
                        bad++;
                        $display("FAIL rand_data idx=%0d got x=%0d y=%0d oob=%b%b exp x=%0d y=%0d oob=00",
                                 rcvd, x_out, y_out, x_oob, y_oob, exp_v[21:11], exp_v[10:0]);
                    end
                end
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (q.size() != 0)
                    void'(q.pop_front());
                rcvd++;
            end
            if (fire_in) begin
                q.push_back({x_in, y_in});
                sent++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (rcvd != 1000 || sent != 1000 || q.size() != 0) begin
            bad++;
            $display("FAIL rand_count got rcvd=%0d sent=%0d pending=%0d exp 1000/1000/0",
                     rcvd, sent, q.size());
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rand_trailing got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_stall_tilt_reset();
        logic [10:0] ox, oy;
        logic        oxo, oyo;
        bit          got;
        logic [10:0] px [3] = '{11'd100, 11'd137, 11'd274};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1; x_in = px[i]; y_in = 11'd400;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== 11'd100 || y_out !== 11'd400) begin
            bad++;
            $display("FAIL stall_full got v=%b rdy=%b x=%0d y=%0d exp v=1 rdy=0 x=100 y=400",
                     out_valid, in_ready, x_out, y_out);
        end
        sin_x = 11'sd120; sin_y = '0; tilt_apply = 1'b1;
        @(negedge clk);
        tilt_apply = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || x_out !== 11'd100 || y_out !== 11'd400) begin
            bad++;
            $display("FAIL stall_hold got v=%b x=%0d y=%0d exp v=1 x=100 y=400",
                     out_valid, x_out, y_out);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || x_out !== px[i] || y_out !== 11'd400 || y_oob !== 1'b0) begin
                bad++;
                $display("FAIL stall_old_tilt[%0d] got v=%b x=%0d y=%0d exp v=1 x=%0d y=400",
                         i, out_valid, x_out, y_out, px[i]);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_drain got valid=%b exp 0", out_valid);
        end
        send_one(11'd100, 11'd400, ox, oy, oxo, oyo, got);
        total++;
        if (!got || ox !== 11'd100 || oy !== 11'd417) begin
            bad++;
            $display("FAIL stall_new_tilt got v=%b x=%0d y=%0d exp x=100 y=417", got, ox, oy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = 1'b1; x_in = px[i]; y_in = 11'd400;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || x_out !== 11'd0 || y_out !== 11'd0) begin
            bad++;
            $display("FAIL async_reset got v=%b x=%0d y=%0d exp v=0 x=0 y=0",
                     out_valid, x_out, y_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0 || (i == 0 && in_ready !== 1'b1)) begin
                bad++;
                $display("FAIL post_reset_quiet[%0d] got v=%b rdy=%b exp v=0 rdy=1",
                         i, out_valid, in_ready);
            end
        end
        send_one(11'd100, 11'd400, ox, oy, oxo, oyo, got);
        total++;
        if (!got || ox !== 11'd100 || oy !== 11'd400 || oxo !== 1'b0 || oyo !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_identity got v=%b x=%0d y=%0d oob=%b%b exp x=100 y=400 oob=00",
                     got, ox, oy, oxo, oyo);
        end
    endtask

    initial begin
        test_reset();
        test_zero_stream();
        test_tilt_x();
        test_tilt_y();
        test_clamp();
        test_back_to_back_random();
        test_stall_tilt_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
